// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter.
// One transaction in flight: IDLE -> ACCESS (gnt) -> RESP (done), with RESP
// able to hand straight over to the next ACCESS for one transaction per two cycles.
//
// state  | meaning
// IDLE   | no transaction, waiting for a request
// ACCESS | command on mem_*, winner's gnt high, memory samples at end of cycle
// RESP   | memory read data on rdata, owner's done high, next winner may be taken
module mem_arbiter #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [3:0]        m0_be,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wd,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [3:0]        m1_be,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wd,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_done,
    output logic              m1_done,
    output logic [31:0]       rdata,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_last;
    logic              r_m0_gnt;
    logic              r_m1_gnt;
    logic              r_m0_done;
    logic              r_m1_done;
    logic              r_mem_we;
    logic [3:0]        r_mem_be;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wd;
    logic [31:0]       r_rdata;

    logic              w_any_req;
    logic              w_win1;
    logic              w_take;
    logic              w_sel_we;
    logic [3:0]        w_sel_be;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wd;

    // Round-robin pick: port 1 wins when alone or when port 0 was granted last.
    always_comb begin
        w_any_req  = m0_req | m1_req;
        w_win1     = m1_req & (~m0_req | ~r_last);
        w_take     = w_any_req & ((r_state == S_IDLE) | (r_state == S_RESP));
        w_sel_we   = w_win1 ? m1_we   : m0_we;
        w_sel_be   = w_win1 ? m1_be   : m0_be;
        w_sel_addr = w_win1 ? m1_addr : m0_addr;
        w_sel_wd   = w_win1 ? m1_wd   : m0_wd;
    end

    // Sequencer: latches the winning command, pulses gnt/done, tracks last grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_m0_gnt   <= 1'b0;
            r_m1_gnt   <= 1'b0;
            r_m0_done  <= 1'b0;
            r_m1_done  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_be   <= 4'b0000;
            r_mem_addr <= '0;
            r_mem_wd   <= '0;
        end else begin
            r_m0_gnt  <= 1'b0;
            r_m1_gnt  <= 1'b0;
            r_m0_done <= 1'b0;
            r_m1_done <= 1'b0;
            r_mem_we  <= 1'b0;
            r_mem_be  <= 4'b0000;
            if (w_take) begin
                r_state    <= S_ACCESS;
                r_owner    <= w_win1;
                r_last     <= w_win1;
                r_m0_gnt   <= ~w_win1;
                r_m1_gnt   <= w_win1;
                r_mem_we   <= w_sel_we;
                r_mem_be   <= w_sel_be;
                r_mem_addr <= w_sel_addr;
                r_mem_wd   <= w_sel_wd;
            end else begin
                case (r_state)
                    S_ACCESS: begin
                        r_state   <= S_RESP;
                        r_m0_done <= ~r_owner;
                        r_m1_done <= r_owner;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Keep the last read word visible on rdata after RESP ends.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (r_state == S_RESP) begin
            r_rdata <= mem_rd;
        end
    end

    assign m0_gnt   = r_m0_gnt;
    assign m1_gnt   = r_m1_gnt;
    assign m0_done  = r_m0_done;
    assign m1_done  = r_m1_done;
    assign mem_we   = r_mem_we;
    assign mem_be   = r_mem_be;
    assign mem_addr = r_mem_addr;
    assign mem_wd   = r_mem_wd;
    assign rdata    = (r_state == S_RESP) ? mem_rd : r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small byte-enable memory behind it.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [3:0]  m0_be, m1_be;
    logic [15:0] m0_addr, m1_addr;
    logic [31:0] m0_wd, m1_wd;
    logic        m0_gnt, m1_gnt, m0_done, m1_done;
    logic [31:0] rdata;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [15:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_arr [0:255];

    mem_arbiter #(.ADDR_W(16)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_done(m0_done), .m1_done(m1_done),
        .rdata(rdata), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // Memory: samples the command on the edge ending ACCESS, read data next cycle.
    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) mem_arr[mem_addr[9:2]][8*b +: 8] <= mem_wd[8*b +: 8];
            end
        end
        mem_rd <= mem_arr[mem_addr[9:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int port, input logic req, input logic we,
                         input logic [3:0] be, input logic [15:0] addr, input logic [31:0] wd);
        if (port == 0) begin
            m0_req = req; m0_we = we; m0_be = be; m0_addr = addr; m0_wd = wd;
        end else begin
            m1_req = req; m1_we = we; m1_be = be; m1_addr = addr; m1_wd = wd;
        end
    endtask

    // Single uncontended transaction from IDLE: gnt next cycle, done the cycle after.
    task automatic xact(input string tag, input int port, input logic we, input logic [3:0] be,
                        input logic [15:0] addr, input logic [31:0] wd,
                        input logic chk_rd, input logic [31:0] exp_rd);
        drive(port, 1'b1, we, be, addr, wd);
        tick();
        chk({tag, "_gnt"},   (port == 0) ? m0_gnt : m1_gnt, 32'd1);
        chk({tag, "_ogn"},   (port == 0) ? m1_gnt : m0_gnt, 32'd0);
        chk({tag, "_we"},    {31'd0, mem_we}, {31'd0, we});
        chk({tag, "_be"},    {28'd0, mem_be}, {28'd0, be});
        chk({tag, "_addr"},  {16'd0, mem_addr}, {16'd0, addr});
        drive(port, 1'b0, 1'b0, 4'h0, addr, wd);
        tick();
        chk({tag, "_done"},  (port == 0) ? m0_done : m1_done, 32'd1);
        chk({tag, "_rwe"},   {31'd0, mem_we}, 32'd0);
        if (chk_rd) chk({tag, "_rdata"}, rdata, exp_rd);
        tick();
        chk({tag, "_idone"}, {30'd0, m0_done, m1_done}, 32'd0);
        chk({tag, "_ibe"},   {28'd0, mem_be}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
        drive(0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        do_reset();

        chk("rst_gnt",  {30'd0, m0_gnt, m1_gnt}, 32'd0);
        chk("rst_done", {30'd0, m0_done, m1_done}, 32'd0);
        chk("rst_we",   {31'd0, mem_we}, 32'd0);
        chk("rst_be",   {28'd0, mem_be}, 32'd0);
        chk("rst_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_wd",   mem_wd, 32'd0);
        chk("rst_rd",   rdata, 32'd0);

        // write then read back
        xact("wr10", 1, 1'b1, 4'hF, 16'h0010, 32'hDEADBEEF, 1'b0, 32'h0);
        xact("rd10", 0, 1'b0, 4'hF, 16'h0010, 32'h0, 1'b1, 32'hDEADBEEF);
        chk("hold_rd", rdata, 32'hDEADBEEF);

        // contention right after reset: port 0 first, port 1 back-to-back
        do_reset();
        drive(0, 1'b1, 1'b0, 4'hF, 16'h0010, 32'h0);
        drive(1, 1'b1, 1'b0, 4'hF, 16'h0014, 32'h0);
        tick();
        chk("ct_g0", {30'd0, m0_gnt, m1_gnt}, 32'd2);
        chk("ct_a0", {16'd0, mem_addr}, 32'h0010);
        drive(0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        tick();
        chk("ct_d0", {30'd0, m0_done, m1_done}, 32'd2);
        tick();
        chk("ct_g1", {30'd0, m0_gnt, m1_gnt}, 32'd1);
        chk("ct_a1", {16'd0, mem_addr}, 32'h0014);
        drive(1, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        tick();
        chk("ct_d1", {30'd0, m0_done, m1_done}, 32'd1);
        tick();

        // sustained contention: grants must alternate 0,1,0,1,0,1
        drive(0, 1'b1, 1'b0, 4'hF, 16'h0040, 32'h0);
        drive(1, 1'b1, 1'b0, 4'hF, 16'h0044, 32'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("rr_g%0d", i), {30'd0, m0_gnt, m1_gnt}, (i % 2 == 0) ? 32'd2 : 32'd1);
            if (i == 5) begin
                drive(0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
                drive(1, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
            end
            tick();
            chk($sformatf("rr_d%0d", i), {30'd0, m0_done, m1_done}, (i % 2 == 0) ? 32'd2 : 32'd1);
        end
        tick();

        // byte write into a known word
        xact("bw_init", 1, 1'b1, 4'hF, 16'h0020, 32'h11223344, 1'b0, 32'h0);
        xact("bw_byte", 1, 1'b1, 4'b0100, 16'h0020, 32'h00AB0000, 1'b0, 32'h0);
        xact("bw_rd",   0, 1'b0, 4'hF, 16'h0020, 32'h0, 1'b1, 32'h11AB3344);

        // write with no byte enables leaves the word untouched
        xact("be0_init", 0, 1'b1, 4'hF, 16'h0030, 32'hCAFEF00D, 1'b0, 32'h0);
        xact("be0_wr",   1, 1'b1, 4'h0, 16'h0030, 32'hFFFFFFFF, 1'b0, 32'h0);
        xact("be0_rd",   1, 1'b0, 4'hF, 16'h0030, 32'h0, 1'b1, 32'hCAFEF00D);

        // address low bits pass through
        xact("lowbits", 0, 1'b0, 4'hF, 16'h0033, 32'h0, 1'b1, 32'hCAFEF00D);

        // reset during ACCESS of a port 0 write aborts it
        drive(0, 1'b1, 1'b1, 4'hF, 16'h0050, 32'h12345678);
        tick();
        chk("ab_gnt", {31'd0, m0_gnt}, 32'd1);
        chk("ab_we",  {31'd0, mem_we}, 32'd1);
        drive(0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        reset = 1'b0;
        tick();
        chk("ab_done", {30'd0, m0_done, m1_done}, 32'd0);
        chk("ab_mwe",  {31'd0, mem_we}, 32'd0);
        chk("ab_mbe",  {28'd0, mem_be}, 32'd0);
        reset = 1'b1;
        xact("ab_next", 1, 1'b0, 4'hF, 16'h0010, 32'h0, 1'b1, 32'hDEADBEEF);

        // request withdrawn before the sampling edge produces nothing
        drive(0, 1'b1, 1'b0, 4'hF, 16'h0010, 32'h0);
        #2;
        drive(0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        tick();
        chk("drop_g", {30'd0, m0_gnt, m1_gnt}, 32'd0);
        tick();
        chk("drop_d", {30'd0, m0_done, m1_done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 16, meaning byte-address width of requester and memory address ports.
REQ-002 The module SHALL have port clk  input  1  rising-edge clock, the single clock of the block.
REQ-003 The module SHALL have port reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 The module SHALL have ports m0_req / m1_req  input  1 each  access request from requester 0 (CPU data) and requester 1 (bridge/DMA).
REQ-005 The module SHALL have ports m0_we / m1_we  input  1 each  1 = write, 0 = read.
REQ-006 The module SHALL have ports m0_be / m1_be  input  4 each  byte enables, bit n = byte n.
REQ-007 The module SHALL have ports m0_addr / m1_addr  input  ADDR_W each  byte address.
REQ-008 The module SHALL have ports m0_wd / m1_wd  input  32 each  write data.
REQ-009 The module SHALL have ports m0_gnt / m1_gnt  output  1 each  one-cycle pulse, command accepted.
REQ-010 The module SHALL have ports m0_done / m1_done  output  1 each  one-cycle pulse, access complete (read data valid on rdata).
REQ-011 The module SHALL have port rdata  output  32  read data, shared by both requesters.
REQ-012 The module SHALL have ports mem_we  output  1, mem_be  output  4, mem_addr  output  ADDR_W, mem_wd  output  32  registered command to the memory controller.
REQ-013 The module SHALL have port mem_rd  input  32  memory read data, valid one cycle after the memory samples the command.

Function
REQ-014 The FSM SHALL have states IDLE, ACCESS, RESP; exactly one transaction is in flight at a time.
REQ-015 IDLE: if any req high at a rising edge, the block SHALL latch the winner's we/be/addr/wd into mem_* and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-016 ACCESS: lasts exactly one cycle; the winner's gnt SHALL be high only in this cycle; mem_we SHALL equal the latched we; next state RESP.
REQ-017 RESP: lasts exactly one cycle; the owner's done SHALL be high; rdata SHALL equal mem_rd for reads; rdata is don't-care for writes.
REQ-018 RESP exit: if any req is high, the block SHALL arbitrate, latch the new command and go directly to ACCESS; otherwise it SHALL go to IDLE.
REQ-019 Peak throughput SHALL be one transaction per 2 cycles; IDLE-to-done latency SHALL be 2 cycles after the request edge.
REQ-020 Arbitration SHALL be round-robin: a sole requester wins; on contention, the port not granted last wins; the last-granted register updates only on grant.
REQ-021 A requester SHALL hold req and its command stable until it sees gnt, and deassert req, or present a new command, in the cycle after gnt.
REQ-022 Outside ACCESS, mem_we SHALL be 0 and mem_be SHALL be 4'b0000; mem_addr and mem_wd SHALL hold their last values.
REQ-023 A write with be = 4'b0000 SHALL complete normally (gnt, then done) with no byte modified.
REQ-024 Address bits [1:0] SHALL pass through to mem_addr unchanged; they are not used by the arbiter.
REQ-025 A request deasserted before grant SHALL be dropped silently; no gnt or done is produced for it.

Reset
REQ-026 When reset = 0 at a rising edge, the state SHALL become IDLE and last-granted SHALL be set to port 1, so port 0 wins the first contention.
REQ-027 Under reset, all gnt, all done, mem_we and mem_be SHALL be 0; mem_addr, mem_wd and rdata SHALL be 0.
REQ-028 A reset in ACCESS or RESP SHALL abort the transaction: no done for it and mem_we is 0 from the next cycle; the memory write in flight in ACCESS is not guaranteed.

Verification
REQ-029 Single read: m0 read addr 0x0010 after a prior write of 0xDEADBEEF -> m0_gnt at T+1, m0_done at T+2 with rdata = 0xDEADBEEF.
REQ-030 Contention after reset: m0 and m1 request at the same edge -> m0 granted first, m1 granted in the following ACCESS with no IDLE gap; done pulses are 2 cycles apart.
REQ-031 Sustained contention over 6 transactions -> grants alternate 0,1,0,1,0,1; no port is granted twice in a row while the other is requesting.
REQ-032 Byte write: m1 write addr 0x0020, be = 4'b0100, wd = 0x00AB0000 onto 0x11223344 -> read-back 0x11AB3344.
REQ-033 Reset mid-ACCESS of an m0 write -> no m0_done; the next cycle has mem_we = 0 and state IDLE; the next m1 request completes in 2 cycles.
REQ-034 Write with be = 4'b0000 to 0x0030 holding 0xCAFEF00D -> gnt and done pulse; read-back 0xCAFEF00D.
